// File: rtl/ddr3_ws_arbiter_if.sv
// Bus bundle around the DDR3 Wishbone arbiter: the cache-line master side and the DDR3 slave side.
// The arbiter uses the slave modport; the surrounding masters and DDR3 slave use the master modport.
interface ddr3_ws_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic [NUM_M*ADDR_W-1:0]   m_addr;
  logic [NUM_M*DATA_W-1:0]   m_din;
  logic [NUM_M*DATA_W/8-1:0] m_dm;
  logic [NUM_M-1:0]          m_cyc;
  logic [NUM_M-1:0]          m_stb;
  logic [NUM_M-1:0]          m_we;
  logic [NUM_M-1:0]          m_ack;
  logic [NUM_M-1:0]          m_err;
  logic [DATA_W-1:0]         m_dout;

  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_din;
  logic [DATA_W/8-1:0]       s_dm;
  logic                      s_cyc;
  logic                      s_stb;
  logic                      s_we;
  logic                      s_ack;
  logic [DATA_W-1:0]         s_dout;

  modport slave (
    input  m_addr, m_din, m_dm, m_cyc, m_stb, m_we,
    output m_ack, m_err, m_dout,
    output s_addr, s_din, s_dm, s_cyc, s_stb, s_we,
    input  s_ack, s_dout
  );

  modport master (
    output m_addr, m_din, m_dm, m_cyc, m_stb, m_we,
    input  m_ack, m_err, m_dout,
    input  s_addr, s_din, s_dm, s_cyc, s_stb, s_we,
    output s_ack, s_dout
  );
endinterface

// File: rtl/ddr3_ws_arbiter.sv
// Round-robin arbiter sharing one 512-bit DDR3 Wishbone slave between NUM_M cache-line masters.
// Optional BUSY watchdog enabled by defining DDR_ARB_TIMEOUT_EN.
module ddr3_ws_arbiter #(
  parameter int NUM_M   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  ddr3_ws_arbiter_if.slave bus,
  output logic [NUM_M-1:0] grant,
  output logic             timeout_flag
);

  localparam int MW = DATA_W / 8;
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last;
  logic [IW-1:0]    pick;
  logic             found;
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] ack_v;
  logic [NUM_M-1:0] err_v;
  logic             tmo_hit;
  int               cand;

  assign req = bus.m_cyc & bus.m_stb;

  // Rotating priority: the master after the previous owner is looked at first.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = (int'(last) + k) % NUM_M;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    ack_v      = '0;
    err_v      = '0;
    bus.s_cyc  = 1'b0;
    bus.s_stb  = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_next = BUSY;
      end
      BUSY: begin
        bus.s_cyc = 1'b1;
        bus.s_stb = 1'b1;
        if (bus.s_ack) begin
          ack_v[owner] = bus.m_cyc[owner];
          state_next   = DONE;
        end else if (tmo_hit) begin
          err_v[owner] = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.m_ack  = ack_v;
  assign bus.m_err  = err_v;
  assign bus.m_dout = bus.s_dout;

  assign bus.s_addr = bus.m_addr[int'(owner)*ADDR_W +: ADDR_W];
  assign bus.s_din  = bus.m_din[int'(owner)*DATA_W +: DATA_W];
  assign bus.s_dm   = bus.m_dm[int'(owner)*MW +: MW];
  assign bus.s_we   = bus.m_we[owner];

  // Reset leaves last at the top index so master 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NUM_M - 1);
      grant <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            grant <= NUM_M'(1) << pick;
          end
        end
        BUSY: ;
        DONE: begin
          last  <= owner;
          grant <= '0;
        end
        default: grant <= '0;
      endcase
    end
  end

`ifdef DDR_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  assign tmo_hit = (state == BUSY) && (cnt == 16'(TIMEOUT));

  // Counter is held at zero outside BUSY so it always starts fresh for a new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state != BUSY) begin
        cnt <= '0;
      end else if (!bus.s_ack) begin
        cnt <= cnt + 16'd1;
        if (tmo_hit) timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_ws_arbiter.sv
// Directed bench for ddr3_ws_arbiter: a transaction-level reference model checked every cycle,
// plus hand-computed expectations for grant order, gaps, routing, abandon and mid-transfer reset.
module tb_ddr3_ws_arbiter;

  localparam int NUM_M   = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;
  localparam int MW      = DATA_W / 8;
  localparam int TIMEOUT = 8;
`ifdef DDR_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NUM_M-1:0] grant;
  logic             timeout_flag;

  int checks = 0;
  int errors = 0;

  ddr3_ws_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr3_ws_arbiter #(
    .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant(grant),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // DDR3 slave stand-in: acks on the ack_delay-th cycle of a strobe run (0 = never acks).
  int               ack_delay  = 0;
  logic [DATA_W-1:0] slave_data = '0;
  int               stb_run    = 0;

  initial begin
    bus.s_ack  = 1'b0;
    bus.s_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.s_dout = slave_data;
      if (bus.s_stb === 1'b1) begin
        stb_run++;
        bus.s_ack = (ack_delay != 0) && (stb_run == ack_delay);
      end else begin
        stb_run   = 0;
        bus.s_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: which master owns the slave, whether the cool-down cycle is running,
  // who went last, and how many BUSY cycles have passed without an ack.
  bit mdl_busy  = 1'b0;
  bit mdl_gap   = 1'b0;
  bit mdl_flag  = 1'b0;
  int mdl_owner = 0;
  int mdl_last  = NUM_M - 1;
  int mdl_cnt   = 0;

  // Observation logs and captured values for the directed checks.
  int               grant_log[$];
  int               gap_log[$];
  int               ack_cnt[NUM_M];
  int               err_cnt[NUM_M];
  int               ack_total = 0;
  logic [NUM_M-1:0] prev_grant = '0;
  bit               prev_stb = 1'b0;
  bit               stb_seen = 1'b0;
  int               low_run = 0;
  int               stb_age = 0;
  int               cap_err_age = -1;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_din;
  logic [MW-1:0]     cap_dm;
  logic [DATA_W-1:0] cap_dout;

  function automatic int pickNext(int last, logic [NUM_M-1:0] req);
    for (int k = 1; k <= NUM_M; k++) begin
      if (req[(last + k) % NUM_M]) return (last + k) % NUM_M;
    end
    return -1;
  endfunction

  task automatic checkOutput(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelStep();
    logic [NUM_M-1:0] req;
    int p;
    req = bus.m_cyc & bus.m_stb;
    p   = pickNext(mdl_last, req);
    if (rst) begin
      mdl_busy = 1'b0; mdl_gap = 1'b0; mdl_flag = 1'b0;
      mdl_last = NUM_M - 1; mdl_cnt = 0;
    end else if (mdl_busy) begin
      if (bus.s_ack === 1'b1) begin
        mdl_busy = 1'b0; mdl_gap = 1'b1;
      end else if (TMO_EN && mdl_cnt == TIMEOUT) begin
        mdl_busy = 1'b0; mdl_gap = 1'b1; mdl_flag = 1'b1;
      end else begin
        mdl_cnt++;
      end
    end else if (mdl_gap) begin
      mdl_gap  = 1'b0;
      mdl_last = mdl_owner;
    end else if (p >= 0) begin
      mdl_owner = p; mdl_busy = 1'b1; mdl_cnt = 0;
    end
  endtask

  task automatic compareCycle();
    logic [NUM_M-1:0] onehot, exp_grant, exp_ack, exp_err;
    bit tmo;
    onehot    = NUM_M'(1) << mdl_owner;
    tmo       = TMO_EN && mdl_busy && (bus.s_ack !== 1'b1) && (mdl_cnt == TIMEOUT);
    exp_grant = (mdl_busy || mdl_gap) ? onehot : '0;
    exp_ack   = (mdl_busy && bus.s_ack === 1'b1 && bus.m_cyc[mdl_owner]) ? onehot : '0;
    exp_err   = tmo ? onehot : '0;
    checkOutput("s_cyc", bus.s_cyc, mdl_busy);
    checkOutput("s_stb", bus.s_stb, mdl_busy);
    checkOutput("grant", grant, exp_grant);
    checkOutput("m_ack", bus.m_ack, exp_ack);
    checkOutput("m_err", bus.m_err, exp_err);
    checkOutput("m_dout", bus.m_dout, bus.s_dout);
    checkOutput("timeout_flag", timeout_flag, mdl_flag);
    if (mdl_busy) begin
      checkOutput("s_addr", bus.s_addr, bus.m_addr[mdl_owner*ADDR_W +: ADDR_W]);
      checkOutput("s_din", bus.s_din, bus.m_din[mdl_owner*DATA_W +: DATA_W]);
      checkOutput("s_dm", bus.s_dm, bus.m_dm[mdl_owner*MW +: MW]);
      checkOutput("s_we", bus.s_we, bus.m_we[mdl_owner]);
    end
    if (grant != '0 && prev_grant == '0) grant_log.push_back(int'(grant));
    prev_grant = grant;
    if (bus.s_stb === 1'b1) begin
      if (!prev_stb && stb_seen) gap_log.push_back(low_run);
      stb_age  = prev_stb ? stb_age + 1 : 0;
      low_run  = 0;
      stb_seen = 1'b1;
    end else begin
      low_run++;
    end
    prev_stb = (bus.s_stb === 1'b1);
    for (int i = 0; i < NUM_M; i++) begin
      if (bus.m_ack[i] === 1'b1) begin
        ack_cnt[i]++;
        ack_total++;
        cap_addr = bus.s_addr; cap_we = bus.s_we; cap_din = bus.s_din;
        cap_dm   = bus.s_dm;   cap_dout = bus.m_dout;
      end
      if (bus.m_err[i] === 1'b1) begin
        err_cnt[i]++;
        cap_err_age = stb_age;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    compareCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(int i, bit req, bit we, logic [ADDR_W-1:0] addr,
                               logic [DATA_W-1:0] din, logic [MW-1:0] dm);
    bus.m_cyc[i] = req;
    bus.m_stb[i] = req;
    bus.m_we[i]  = we;
    bus.m_addr[i*ADDR_W +: ADDR_W] = addr;
    bus.m_din[i*DATA_W +: DATA_W]  = din;
    bus.m_dm[i*MW +: MW]           = dm;
  endtask

  task automatic bound(string name, bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s actual=timeout required=event", name);
    end
  endtask

  task automatic waitAck(int i, int target, int maxc, string name);
    bit ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (ack_cnt[i] >= target) begin ok = 1'b1; break; end
      cycle();
    end
    bound(name, ok);
  endtask

  task automatic waitAckTotal(int target, int maxc, string name);
    bit ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (ack_total >= target) begin ok = 1'b1; break; end
      cycle();
    end
    bound(name, ok);
  endtask

  task automatic waitGrant(int target, int maxc, string name);
    bit ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (grant_log.size() >= target) begin ok = 1'b1; break; end
      cycle();
    end
    bound(name, ok);
  endtask

  int gb, a0, a1, ng;

  initial begin
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
    bus.m_addr = '0; bus.m_din = '0; bus.m_dm = '0;
    for (int i = 0; i < NUM_M; i++) begin ack_cnt[i] = 0; err_cnt[i] = 0; end
    rst = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
    cycle();
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_s_cyc", bus.s_cyc, 0);
    checkOutput("reset_tflag", timeout_flag, 0);
    rst = 1'b0;
    cycle();

    $display("[TB] both masters request together");
    ack_delay = 2;
    gb = grant_log.size();
    applyStimulus(0, 1, 0, 32'h0000_1000, '0, '1);
    applyStimulus(1, 1, 0, 32'h0000_2000, '0, '1);
    waitAckTotal(ack_total + 4, 60, "wait_rr4");
    applyStimulus(0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0, '0);
    repeat (4) cycle();
    checkOutput("rr_count", grant_log.size() - gb, 4);
    checkOutput("rr_g0", (grant_log.size() > gb)     ? grant_log[gb]     : -1, 1);
    checkOutput("rr_g1", (grant_log.size() > gb + 1) ? grant_log[gb + 1] : -1, 2);
    checkOutput("rr_g2", (grant_log.size() > gb + 2) ? grant_log[gb + 2] : -1, 1);
    checkOutput("rr_g3", (grant_log.size() > gb + 3) ? grant_log[gb + 3] : -1, 2);
    ng = gap_log.size();
    for (int k = 1; k <= 3; k++)
      checkOutput("rr_gap", (ng >= k) ? gap_log[ng - k] : -1, 2);

    $display("[TB] m0 read");
    ack_delay  = 6;
    slave_data = {64{8'hA5}};
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    applyStimulus(0, 1, 0, 32'h0000_0100, '0, '1);
    waitAck(0, a0 + 1, 30, "wait_rd_ack");
    applyStimulus(0, 0, 0, '0, '0, '0);
    repeat (4) cycle();
    checkOutput("rd_addr", cap_addr, 32'h0000_0100);
    checkOutput("rd_we", cap_we, 0);
    checkOutput("rd_dout", cap_dout, {64{8'hA5}});
    checkOutput("rd_ack0", ack_cnt[0] - a0, 1);
    checkOutput("rd_ack1", ack_cnt[1] - a1, 0);

    $display("[TB] m1 write");
    ack_delay = 3;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    applyStimulus(1, 1, 1, 32'h0000_0400, {32{16'h1234}}, {32'hFFFF_FFFF, 32'h0000_0000});
    waitAck(1, a1 + 1, 30, "wait_wr_ack");
    applyStimulus(1, 0, 0, '0, '0, '0);
    repeat (4) cycle();
    checkOutput("wr_we", cap_we, 1);
    checkOutput("wr_din", cap_din, {32{16'h1234}});
    checkOutput("wr_dm", cap_dm, {32'hFFFF_FFFF, 32'h0000_0000});
    checkOutput("wr_ack1", ack_cnt[1] - a1, 1);
    checkOutput("wr_ack0", ack_cnt[0] - a0, 0);

    $display("[TB] m0 abandons its cycle");
    ack_delay = 6;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    gb = grant_log.size();
    applyStimulus(0, 1, 0, 32'h0000_0200, '0, '1);
    waitGrant(gb + 1, 20, "wait_ab_grant");
    applyStimulus(1, 1, 0, 32'h0000_0208, '0, '1);
    cycle();
    applyStimulus(0, 0, 0, '0, '0, '0);
    waitAck(1, a1 + 1, 40, "wait_ab_m1");
    applyStimulus(1, 0, 0, '0, '0, '0);
    repeat (4) cycle();
    checkOutput("ab_ack0", ack_cnt[0] - a0, 0);
    checkOutput("ab_first", (grant_log.size() > gb)     ? grant_log[gb]     : -1, 1);
    checkOutput("ab_next",  (grant_log.size() > gb + 1) ? grant_log[gb + 1] : -1, 2);

    $display("[TB] reset during BUSY");
    ack_delay = 0;
    gb = grant_log.size();
    applyStimulus(1, 1, 0, 32'h0000_0300, '0, '1);
    waitGrant(gb + 1, 20, "wait_rs_grant");
    cycle();
    rst = 1'b1;
    applyStimulus(0, 1, 0, 32'h0000_0310, '0, '1);
    cycle();
    checkOutput("rs_s_cyc", bus.s_cyc, 0);
    checkOutput("rs_grant", grant, 0);
    rst = 1'b0;
    ack_delay = 2;
    gb = grant_log.size();
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    waitAck(0, a0 + 1, 20, "wait_rs_m0");
    applyStimulus(0, 0, 0, '0, '0, '0);
    waitAck(1, a1 + 1, 20, "wait_rs_m1");
    applyStimulus(1, 0, 0, '0, '0, '0);
    repeat (4) cycle();
    checkOutput("rs_first", (grant_log.size() > gb) ? grant_log[gb] : -1, 1);

`ifdef DDR_ARB_TIMEOUT_EN
    $display("[TB] slave never acks");
    ack_delay = 0;
    a0 = err_cnt[0];
    applyStimulus(0, 1, 0, 32'h0000_0500, '0, '1);
    for (int c = 0; c < 40; c++) begin
      if (err_cnt[0] > a0) break;
      cycle();
    end
    bound("wait_tmo_err", err_cnt[0] > a0);
    checkOutput("tmo_age", cap_err_age, 8);
    checkOutput("tmo_flag", timeout_flag, 1);
    applyStimulus(0, 0, 0, '0, '0, '0);
    repeat (3) cycle();
    checkOutput("tmo_idle_grant", grant, 0);
    checkOutput("tmo_flag_sticky", timeout_flag, 1);
`else
    checkOutput("no_tmo_flag", timeout_flag, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
